// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-port data memory, with bounded lock for RMW.
// Optional DMEM_ARB_PERF_EN adds conflict_cnt/force_cnt performance counters.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]   conflict_cnt,
  output logic [15:0]   force_cnt,
`endif
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] LOCK_LIMIT = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          last_q, last_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;

  logic owner_hold, other_req, at_limit, force_ho;
  logic sel0, sel1;

  // Grant selection: a held lock beats round-robin until it has run MAX_LOCK cycles.
  always_comb begin
    owner_hold = ((owner_q == OWN_P0) && req0) || ((owner_q == OWN_P1) && req1);
    other_req  = (owner_q == OWN_P0) ? req1 : req0;
    at_limit   = (lock_cnt_q == LOCK_LIMIT);
    force_ho   = owner_hold && at_limit && other_req;
    sel0       = 1'b0;
    sel1       = 1'b0;
    if (force_ho) begin
      sel0 = (owner_q == OWN_P1);
      sel1 = (owner_q == OWN_P0);
    end else if (owner_hold) begin
      sel0 = (owner_q == OWN_P0);
      sel1 = (owner_q == OWN_P1);
    end else if (req0 && req1) begin
      sel0 = last_q;
      sel1 = !last_q;
    end else begin
      sel0 = req0;
      sel1 = req1;
    end
  end

  // lock_cnt restarts at 0 on a fresh acquisition, so the limit means MAX_LOCK grants.
  always_comb begin
    last_d     = last_q;
    owner_d    = OWN_NONE;
    lock_cnt_d = '0;
    if (sel0) begin
      last_d = 1'b0;
      if (lock0) begin
        owner_d = OWN_P0;
        if (owner_q == OWN_P0)
          lock_cnt_d = at_limit ? lock_cnt_q : lock_cnt_q + 1'b1;
      end
    end else if (sel1) begin
      last_d = 1'b1;
      if (lock1) begin
        owner_d = OWN_P1;
        if (owner_q == OWN_P1)
          lock_cnt_d = at_limit ? lock_cnt_q : lock_cnt_q + 1'b1;
      end
    end
    rvalid0_d = sel0 && !we0;
    rvalid1_d = sel1 && !we1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_NONE;
      lock_cnt_q <= '0;
      last_q     <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      last_q     <= last_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (sel1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign gnt0    = sel0;
  assign gnt1    = sel1;
  assign mem_en  = sel0 | sel1;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] force_cnt_q, force_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q + {31'd0, (req0 & req1)};
    force_cnt_d    = force_cnt_q + {15'd0, force_ho};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt_q <= '0;
      force_cnt_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      force_cnt_q    <= force_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign force_cnt    = force_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, write/read, round-robin, bounded lock, lock drop.
// Also checks the perf counters when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   conflict_cnt;
  logic [15:0]   force_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  always #5 clk = ~clk;

  // One-cycle-latency RAM model driven by the arbiter's command bus
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
`ifdef DMEM_ARB_PERF_EN
    .conflict_cnt(conflict_cnt), .force_cnt(force_cnt),
`endif
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the negedge, then check grants and last cycle's rvalid
  task automatic apply_stimulus(
    input int n,
    input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic r1, input logic w1, input logic l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic eg0, input logic eg1, input logic ev0, input logic ev1,
    input logic chk_rd, input logic [DW-1:0] erd);
    @(negedge clk);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
    check_output($sformatf("c%0d gnt0", n), {63'd0, gnt0}, {63'd0, eg0});
    check_output($sformatf("c%0d gnt1", n), {63'd0, gnt1}, {63'd0, eg1});
    check_output($sformatf("c%0d mem_en", n), {63'd0, mem_en}, {63'd0, eg0 | eg1});
    check_output($sformatf("c%0d rvalid0", n), {63'd0, rvalid0}, {63'd0, ev0});
    check_output($sformatf("c%0d rvalid1", n), {63'd0, rvalid1}, {63'd0, ev1});
    if (chk_rd)
      check_output($sformatf("c%0d rdata", n), {32'd0, rdata}, {32'd0, erd});
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = 32'hA000_0000 | i;
    mem_rdata = '0;
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #3;
    check_output("rst gnt0", {63'd0, gnt0}, 64'd0);
    check_output("rst gnt1", {63'd0, gnt1}, 64'd0);
    check_output("rst mem_en", {63'd0, mem_en}, 64'd0);
    check_output("rst mem_addr", {54'd0, mem_addr}, 64'd0);
    check_output("rst rvalid0", {63'd0, rvalid0}, 64'd0);
    check_output("rst rvalid1", {63'd0, rvalid1}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Round-robin reads: port 0 first after reset, then alternate
    apply_stimulus(1, 1,0,0,10'd5,0, 1,0,0,10'd6,0, 1,0, 0,0, 0,0);
    apply_stimulus(2, 1,0,0,10'd5,0, 1,0,0,10'd6,0, 0,1, 1,0, 1,32'hA000_0005);
    apply_stimulus(3, 1,0,0,10'd5,0, 1,0,0,10'd6,0, 1,0, 0,1, 1,32'hA000_0006);
    apply_stimulus(4, 1,0,0,10'd5,0, 1,0,0,10'd6,0, 0,1, 1,0, 1,32'hA000_0005);
    apply_stimulus(5, 1,0,0,10'd5,0, 1,0,0,10'd6,0, 1,0, 0,1, 0,0);
    apply_stimulus(6, 1,0,0,10'd5,0, 1,0,0,10'd6,0, 0,1, 1,0, 0,0);
    apply_stimulus(7, 0,0,0,10'd0,0, 0,0,0,10'd0,0, 0,0, 0,1, 1,32'hA000_0006);

    // Write then read the same address from port 0
    apply_stimulus(8, 1,1,0,10'd5,32'hDEADBEEF, 0,0,0,10'd0,0, 1,0, 0,0, 0,0);
    check_output("c8 mem_we", {63'd0, mem_we}, 64'd1);
    check_output("c8 mem_addr", {54'd0, mem_addr}, 64'd5);
    check_output("c8 mem_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
    apply_stimulus(9, 1,0,0,10'd5,0, 0,0,0,10'd0,0, 1,0, 0,0, 0,0);
    check_output("c9 mem_we", {63'd0, mem_we}, 64'd0);
    apply_stimulus(10, 0,0,0,10'd0,0, 0,0,0,10'd0,0, 0,0, 1,0, 1,32'hDEADBEEF);
    check_output("c10 mem_wdata idle", {32'd0, mem_wdata}, 64'd0);

    // Port 1 locks: four grants, forced hand-over to port 0, then port 1 again
    apply_stimulus(11, 1,1,0,10'd7,32'h12345678, 1,0,1,10'd6,0, 0,1, 0,0, 0,0);
    check_output("c11 mem_addr", {54'd0, mem_addr}, 64'd6);
    apply_stimulus(12, 1,1,0,10'd7,32'h12345678, 1,0,1,10'd6,0, 0,1, 0,1, 0,0);
    apply_stimulus(13, 1,1,0,10'd7,32'h12345678, 1,0,1,10'd6,0, 0,1, 0,1, 0,0);
    apply_stimulus(14, 1,1,0,10'd7,32'h12345678, 1,0,1,10'd6,0, 0,1, 0,1, 0,0);
    apply_stimulus(15, 1,1,0,10'd7,32'h12345678, 1,0,1,10'd6,0, 1,0, 0,1, 0,0);
    apply_stimulus(16, 1,1,0,10'd7,32'h12345678, 1,0,1,10'd6,0, 0,1, 0,0, 0,0);
`ifdef DMEM_ARB_PERF_EN
    check_output("c16 force_cnt", {48'd0, force_cnt}, 64'd1);
`endif

    // Owner drops its request: port 0 wins and the lock count restarts
    apply_stimulus(17, 1,0,0,10'd7,0, 0,0,0,10'd6,0, 1,0, 0,1, 1,32'hA000_0006);
    apply_stimulus(18, 1,0,0,10'd7,0, 1,0,1,10'd6,0, 0,1, 1,0, 1,32'h12345678);
    apply_stimulus(19, 1,0,0,10'd7,0, 1,0,1,10'd6,0, 0,1, 0,1, 0,0);
    apply_stimulus(20, 1,0,0,10'd7,0, 1,0,1,10'd6,0, 0,1, 0,1, 0,0);
    apply_stimulus(21, 1,0,0,10'd7,0, 1,0,1,10'd6,0, 0,1, 0,1, 0,0);
    apply_stimulus(22, 1,0,0,10'd7,0, 1,0,1,10'd6,0, 1,0, 0,1, 0,0);
    apply_stimulus(23, 0,0,0,10'd0,0, 0,0,0,10'd0,0, 0,0, 1,0, 1,32'h12345678);
`ifdef DMEM_ARB_PERF_EN
    check_output("c23 force_cnt", {48'd0, force_cnt}, 64'd2);
    check_output("c23 conflict_cnt", {32'd0, conflict_cnt}, 64'd17);
`endif

    // Reset asserted while a read is in flight: no rvalid, then port 0 wins first tie
    apply_stimulus(24, 1,0,0,10'd5,0, 0,0,0,10'd0,0, 1,0, 0,0, 0,0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check_output("rst mid-read rvalid0", {63'd0, rvalid0}, 64'd0);
`ifdef DMEM_ARB_PERF_EN
    check_output("rst force_cnt", {48'd0, force_cnt}, 64'd0);
`endif
    @(negedge clk);
    req0 = 1'b0;
    reset = 1'b1;
    apply_stimulus(25, 0,0,0,10'd0,0, 0,0,0,10'd0,0, 0,0, 0,0, 0,0);
    apply_stimulus(26, 1,0,0,10'd5,0, 1,0,0,10'd6,0, 1,0, 0,0, 0,0);
    apply_stimulus(27, 0,0,0,10'd0,0, 0,0,0,10'd0,0, 0,0, 1,0, 1,32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
